// File: rtl/amount_entry.sv
// amount_entry: two-digit keypad amount entry with synchronized key inputs and one-cycle strobes.
// Optional idle timeout: define ENTRY_TIMEOUT_EN to abandon unfinished entries after TIMEOUT_CYCLES.
module amount_entry #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       keydown_num,
    input  logic       keydown_confirm,
    input  logic       keydown_clear,
    input  logic       keydown_start,
    input  logic [3:0] num,
    output logic [6:0] entry_value,
    output logic [1:0] entry_digits,
    output logic [6:0] confirmed_value,
    output logic       confirm_pulse,
    output logic       start_pulse,
    output logic       error_pulse
);

    typedef enum logic [1:0] {IDLE = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    // Packed key vectors use bit order {start, clear, confirm, num}.
    logic [3:0] key_meta_r, key_sync_r, key_prev_r, key_evt_s;
    logic [3:0] num_meta_r, num_sync_r;
    logic       evt_num_s, evt_confirm_s, evt_clear_s, evt_start_s;

    state_t     state_r, state_next_s;
    logic [6:0] entry_value_r, value_next_s;
    logic [1:0] entry_digits_r, digits_next_s;
    logic [6:0] confirmed_value_r, confirmed_next_s;
    logic       confirm_pulse_r, confirm_next_s;
    logic       start_pulse_r, start_next_s;
    logic       error_pulse_r, error_next_s;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("amount_entry: TIMEOUT_CYCLES must be at least 2");
    end

`ifdef ENTRY_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] timeout_cnt_r, cnt_next_s;
    logic             timeout_s;

    assign timeout_s = (state_r != IDLE) && (timeout_cnt_r == CNT_MAX);

    // Timeout counter next value: zero in IDLE and whenever a digit is accepted.
    always_comb begin
        cnt_next_s = timeout_cnt_r;
        if ((state_next_s == IDLE) || (state_next_s != state_r)) begin
            cnt_next_s = {CNT_W{1'b0}};
        end else begin
            cnt_next_s = timeout_cnt_r + CNT_W'(1);
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_cnt_r <= {CNT_W{1'b0}};
        end else begin
            timeout_cnt_r <= cnt_next_s;
        end
    end
`endif

    // Two-flop synchronizers plus previous-level registers for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_meta_r <= 4'd0;
            key_sync_r <= 4'd0;
            key_prev_r <= 4'd0;
            num_meta_r <= 4'd0;
            num_sync_r <= 4'd0;
        end else begin
            key_meta_r <= {keydown_start, keydown_clear, keydown_confirm, keydown_num};
            key_sync_r <= key_meta_r;
            key_prev_r <= key_sync_r;
            num_meta_r <= num;
            num_sync_r <= num_meta_r;
        end
    end

    assign key_evt_s     = key_sync_r & ~key_prev_r;
    assign evt_num_s     = key_evt_s[0];
    assign evt_confirm_s = key_evt_s[1];
    assign evt_clear_s   = key_evt_s[2];
    assign evt_start_s   = key_evt_s[3];

    // Next-state and output logic; clear beats confirm beats num, start always strobes.
    always_comb begin
        state_next_s     = state_r;
        value_next_s     = entry_value_r;
        confirmed_next_s = confirmed_value_r;
        confirm_next_s   = 1'b0;
        error_next_s     = 1'b0;
        start_next_s     = evt_start_s;
        if (evt_clear_s) begin
            state_next_s = IDLE;
            value_next_s = 7'd0;
        end else if (evt_confirm_s) begin
            if ((state_r != IDLE) && (entry_value_r != 7'd0)) begin
                confirmed_next_s = entry_value_r;
                confirm_next_s   = 1'b1;
            end else begin
                error_next_s = 1'b1;
            end
            state_next_s = IDLE;
            value_next_s = 7'd0;
        end else if (evt_num_s) begin
            if (num_sync_r > 4'd9) begin
                error_next_s = 1'b1;
            end else begin
                case (state_r)
                    IDLE: begin
                        state_next_s = ONE;
                        value_next_s = {3'd0, num_sync_r};
                    end
                    ONE: begin
                        state_next_s = TWO;
                        value_next_s = entry_value_r * 7'd10 + {3'd0, num_sync_r};
                    end
                    TWO: begin
                        error_next_s = 1'b1;
                    end
                    default: begin
                        state_next_s = IDLE;
                        value_next_s = 7'd0;
                    end
                endcase
            end
        end else begin
`ifdef ENTRY_TIMEOUT_EN
            if (timeout_s) begin
                state_next_s = IDLE;
                value_next_s = 7'd0;
                error_next_s = 1'b1;
            end else begin
                state_next_s = state_r;
            end
`else
            state_next_s = state_r;
`endif
        end
    end

    // Digit count follows the next state so it is registered alongside it.
    always_comb begin
        digits_next_s = 2'd0;
        case (state_next_s)
            IDLE:    digits_next_s = 2'd0;
            ONE:     digits_next_s = 2'd1;
            TWO:     digits_next_s = 2'd2;
            default: digits_next_s = 2'd0;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r           <= IDLE;
            entry_value_r     <= 7'd0;
            entry_digits_r    <= 2'd0;
            confirmed_value_r <= 7'd0;
            confirm_pulse_r   <= 1'b0;
            start_pulse_r     <= 1'b0;
            error_pulse_r     <= 1'b0;
        end else begin
            state_r           <= state_next_s;
            entry_value_r     <= value_next_s;
            entry_digits_r    <= digits_next_s;
            confirmed_value_r <= confirmed_next_s;
            confirm_pulse_r   <= confirm_next_s;
            start_pulse_r     <= start_next_s;
            error_pulse_r     <= error_next_s;
        end
    end

    assign entry_value     = entry_value_r;
    assign entry_digits    = entry_digits_r;
    assign confirmed_value = confirmed_value_r;
    assign confirm_pulse   = confirm_pulse_r;
    assign start_pulse     = start_pulse_r;
    assign error_pulse     = error_pulse_r;

endmodule

// File: tb/tb_amount_entry.sv
// tb_amount_entry: table-driven key presses checked through an expected-output scoreboard,
// plus hand sequences for long hold, asynchronous reset and idle timeout.
module tb_amount_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       keydown_num = 1'b0, keydown_confirm = 1'b0, keydown_clear = 1'b0, keydown_start = 1'b0;
    logic [3:0] num = 4'd0;
    logic [6:0] entry_value, confirmed_value;
    logic [1:0] entry_digits;
    logic       confirm_pulse, start_pulse, error_pulse;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    amount_entry #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst),
        .keydown_num(keydown_num), .keydown_confirm(keydown_confirm),
        .keydown_clear(keydown_clear), .keydown_start(keydown_start),
        .num(num),
        .entry_value(entry_value), .entry_digits(entry_digits),
        .confirmed_value(confirmed_value),
        .confirm_pulse(confirm_pulse), .start_pulse(start_pulse), .error_pulse(error_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       kn, kc, kcl, ks;
        logic [3:0] n;
        logic [6:0] val;
        logic [1:0] dig;
        logic [6:0] conf;
        logic       cp, sp, ep;
    } vec_t;

    typedef struct {
        int         due;
        logic [6:0] val;
        logic [1:0] dig;
        logic [6:0] conf;
        logic       cp, sp, ep;
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    vec_t tbl[24];

    function automatic vec_t v(input logic kn, kc, kcl, ks, input logic [3:0] n,
                               input logic [6:0] val, input logic [1:0] dig, input logic [6:0] conf,
                               input logic cp, sp, ep);
        vec_t r;
        r.kn = kn; r.kc = kc; r.kcl = kcl; r.ks = ks; r.n = n;
        r.val = val; r.dig = dig; r.conf = conf; r.cp = cp; r.sp = sp; r.ep = ep;
        return r;
    endfunction

    task automatic push_at(input int due, input logic [6:0] val, input logic [1:0] dig,
                           input logic [6:0] conf, input logic cp, sp, ep);
        exp_t x;
        x.due = due; x.val = val; x.dig = dig; x.conf = conf; x.cp = cp; x.sp = sp; x.ep = ep;
        sbq.push_back(x);
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Press keys for two cycles; the registered response is due three edges after the drive.
    task automatic press(input vec_t p, output int c0);
        @(posedge clk); #1;
        keydown_num = p.kn; keydown_confirm = p.kc; keydown_clear = p.kcl; keydown_start = p.ks;
        num = p.n;
        c0 = cyc;
        push_at(c0 + 3, p.val, p.dig, p.conf, p.cp, p.sp, p.ep);
        repeat (2) @(posedge clk); #1;
        keydown_num = 1'b0; keydown_confirm = 1'b0; keydown_clear = 1'b0; keydown_start = 1'b0;
        num = 4'd0;
        repeat (4) @(posedge clk);
    endtask

    // Scoreboard: compare due records, otherwise require all strobes low.
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e = sbq.pop_front();
            checks++;
            if ({entry_value, entry_digits, confirmed_value, confirm_pulse, start_pulse, error_pulse} !==
                {e.val, e.dig, e.conf, e.cp, e.sp, e.ep}) begin
                errors++;
                $display("FAIL sb@%0d: got val=%0d dig=%0d conf=%0d cp/sp/ep=%b%b%b, expected val=%0d dig=%0d conf=%0d cp/sp/ep=%b%b%b",
                         cyc, entry_value, entry_digits, confirmed_value, confirm_pulse, start_pulse, error_pulse,
                         e.val, e.dig, e.conf, e.cp, e.sp, e.ep);
            end
        end else begin
            checks++;
            if ({confirm_pulse, start_pulse, error_pulse} !== 3'b000) begin
                errors++;
                $display("FAIL spurious_pulse@%0d: got cp/sp/ep=%b%b%b, expected 000",
                         cyc, confirm_pulse, start_pulse, error_pulse);
            end
        end
    end

    initial begin
        int c0;
        //                kn    kc    kcl   ks    num    val    dig   conf   cp    sp    ep
        tbl[0]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd4,  7'd4,  2'd1, 7'd0,  1'b0, 1'b0, 1'b0);
        tbl[1]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd2,  7'd42, 2'd2, 7'd0,  1'b0, 1'b0, 1'b0);
        tbl[2]  = v(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  7'd0,  2'd0, 7'd42, 1'b1, 1'b0, 1'b0);
        tbl[3]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd7,  7'd7,  2'd1, 7'd42, 1'b0, 1'b0, 1'b0);
        tbl[4]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  7'd73, 2'd2, 7'd42, 1'b0, 1'b0, 1'b0);
        tbl[5]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd5,  7'd73, 2'd2, 7'd42, 1'b0, 1'b0, 1'b1);
        tbl[6]  = v(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  7'd0,  2'd0, 7'd73, 1'b1, 1'b0, 1'b0);
        tbl[7]  = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  7'd0,  2'd1, 7'd73, 1'b0, 1'b0, 1'b0);
        tbl[8]  = v(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  7'd0,  2'd0, 7'd73, 1'b0, 1'b0, 1'b1);
        tbl[9]  = v(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  7'd0,  2'd0, 7'd73, 1'b0, 1'b0, 1'b1);
        tbl[10] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  7'd9,  2'd1, 7'd73, 1'b0, 1'b0, 1'b0);
        tbl[11] = v(1'b0, 1'b1, 1'b1, 1'b0, 4'd0,  7'd0,  2'd0, 7'd73, 1'b0, 1'b0, 1'b0);
        tbl[12] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd12, 7'd0,  2'd0, 7'd73, 1'b0, 1'b0, 1'b1);
        tbl[13] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd8,  7'd8,  2'd1, 7'd73, 1'b0, 1'b0, 1'b0);
        tbl[14] = v(1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  7'd8,  2'd1, 7'd73, 1'b0, 1'b1, 1'b0);
        tbl[15] = v(1'b1, 1'b0, 1'b0, 1'b1, 4'd6,  7'd86, 2'd2, 7'd73, 1'b0, 1'b1, 1'b0);
        tbl[16] = v(1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  7'd0,  2'd0, 7'd86, 1'b1, 1'b0, 1'b0);
        tbl[17] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd3,  7'd3,  2'd1, 7'd86, 1'b0, 1'b0, 1'b0);
        tbl[18] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 7'd3,  2'd1, 7'd86, 1'b0, 1'b0, 1'b1);
        tbl[19] = v(1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  7'd0,  2'd0, 7'd86, 1'b0, 1'b0, 1'b0);
        tbl[20] = v(1'b0, 1'b0, 1'b1, 1'b1, 4'd0,  7'd0,  2'd0, 7'd86, 1'b0, 1'b1, 1'b0);
        tbl[21] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  7'd9,  2'd1, 7'd86, 1'b0, 1'b0, 1'b0);
        tbl[22] = v(1'b1, 1'b0, 1'b0, 1'b0, 4'd9,  7'd99, 2'd2, 7'd86, 1'b0, 1'b0, 1'b0);
        tbl[23] = v(1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  7'd0,  2'd0, 7'd99, 1'b1, 1'b0, 1'b0);

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_entry_value", entry_value, 0);
        chk("reset_entry_digits", entry_digits, 0);
        chk("reset_confirmed_value", confirmed_value, 0);
        chk("reset_confirm_pulse", confirm_pulse, 0);
        chk("reset_start_pulse", start_pulse, 0);
        chk("reset_error_pulse", error_pulse, 0);
        @(posedge clk); #1 rst = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < 24; i++) begin
            press(tbl[i], c0);
        end
        // All four keys together: clear wins, start still strobes.
        press(v(1'b1, 1'b1, 1'b1, 1'b1, 4'd4, 7'd0, 2'd0, 7'd99, 1'b0, 1'b1, 1'b0), c0);

        // Hold digit 5 for 1000 cycles: exactly one event.
        @(posedge clk); #1;
        keydown_num = 1'b1; num = 4'd5;
        c0 = cyc;
        push_at(c0 + 3, 7'd5, 2'd1, 7'd99, 1'b0, 1'b0, 1'b0);
`ifdef ENTRY_TIMEOUT_EN
        push_at(c0 + 19, 7'd0, 2'd0, 7'd99, 1'b0, 1'b0, 1'b1);
`endif
        repeat (1000) @(posedge clk);
        #1;
`ifdef ENTRY_TIMEOUT_EN
        chk("hold_entry_value", entry_value, 0);
        chk("hold_entry_digits", entry_digits, 0);
`else
        chk("hold_entry_value", entry_value, 5);
        chk("hold_entry_digits", entry_digits, 1);
`endif
        chk("hold_confirmed_value", confirmed_value, 99);

        // Asynchronous reset mid-hold clears outputs before the next clock edge.
        @(negedge clk); #2 rst = 1'b1;
        #1;
        chk("async_rst_entry_value", entry_value, 0);
        chk("async_rst_entry_digits", entry_digits, 0);
        chk("async_rst_confirmed_value", confirmed_value, 0);
        repeat (2) @(posedge clk);

        // Key still held through reset release yields a single event.
        @(posedge clk); #1 rst = 1'b0;
        c0 = cyc;
        push_at(c0 + 3, 7'd5, 2'd1, 7'd0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk); #1;
        keydown_num = 1'b0; num = 4'd0;
        repeat (5) @(posedge clk); #1;
        chk("post_rst_entry_value", entry_value, 5);
        chk("post_rst_entry_digits", entry_digits, 1);

        // Idle timeout after a single digit.
        press(v(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 7'd0, 2'd0, 7'd0, 1'b0, 1'b0, 1'b0), c0);
        press(v(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 7'd6, 2'd1, 7'd0, 1'b0, 1'b0, 1'b0), c0);
`ifdef ENTRY_TIMEOUT_EN
        push_at(c0 + 19, 7'd0, 2'd0, 7'd0, 1'b0, 1'b0, 1'b1);
`else
        push_at(c0 + 19, 7'd6, 2'd1, 7'd0, 1'b0, 1'b0, 1'b0);
`endif
        repeat (20) @(posedge clk);
        #1;
        chk("timeout_final_entry_digits", entry_digits, 
`ifdef ENTRY_TIMEOUT_EN
            0
`else
            1
`endif
        );

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
